// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter:
// opcode map, illegal-op boundary and controller states.
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_SRL    = 3'b100;
  localparam logic [2:0] ALU_SRA    = 3'b101;
  // Every opcode at or above this value is illegal.
  localparam logic [2:0] ALU_ILL_LO = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational ALU shared by both arbiter ports.
// Ports: i_a, i_b, i_op in; o_c result, o_err illegal op.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OPW-1:0]   i_op,
  output logic [WIDTH-1:0] o_c,
  output logic             o_err
);

  assign o_err = (i_op >= OPW'(ALU_ILL_LO));

  // Shifts use the whole B value: amounts of WIDTH
  // or more give zero / full sign fill.
  always_comb begin
    o_c = '0;
    case (i_op)
      OPW'(ALU_ADD): o_c = i_a + i_b;
      OPW'(ALU_SUB): o_c = i_a - i_b;
      OPW'(ALU_AND): o_c = i_a & i_b;
      OPW'(ALU_OR):  o_c = i_a | i_b;
      OPW'(ALU_SRL): o_c = i_a >> i_b;
      OPW'(ALU_SRA): o_c = $unsigned($signed(i_a) >>> i_b);
      default:       o_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two ports.
// Ports: clk, reset, req0/req1 cmd channels, resp0/resp1.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic             resp1_err
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_last;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_err;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_hs;
  logic             w_acc;
  logic [WIDTH-1:0] w_c;
  logic             w_err;

  // r_last holds the last winner; on a tie the
  // other port wins.
  assign w_gnt0 = req0_valid & (~req1_valid | r_last);
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

  // Reset gating keeps ready low for the whole time
  // reset is held, not just after the first edge.
  assign req0_ready = (r_state == S_IDLE) & w_gnt0 & ~reset;
  assign req1_ready = (r_state == S_IDLE) & w_gnt1 & ~reset;
  assign w_hs = req0_ready | req1_ready;

  assign resp0_valid = (r_state == S_RESP) & ~r_owner;
  assign resp1_valid = (r_state == S_RESP) & r_owner;
  assign resp0_data  = resp0_valid ? r_res : '0;
  assign resp1_data  = resp1_valid ? r_res : '0;
  assign resp0_err   = resp0_valid & r_err;
  assign resp1_err   = resp1_valid & r_err;

  // The non-owner's resp_ready is masked out here.
  assign w_acc = (resp0_valid & resp0_ready)
               | (resp1_valid & resp1_ready);

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_c   (w_c),
    .o_err (w_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_acc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_owner <= req1_ready;
        r_last  <= req1_ready;
        r_a     <= req1_ready ? req1_a  : req0_a;
        r_b     <= req1_ready ? req1_b  : req0_b;
        r_op    <= req1_ready ? req1_op : req0_op;
      end
      if (r_state == S_EXEC) begin
        r_res <= w_c;
        r_err <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// Directed scenarios plus a randomized scoreboard run.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        resp0_valid, resp0_ready, resp0_err;
  logic [31:0] resp0_data;
  logic        resp1_valid, resp1_ready, resp1_err;
  logic [31:0] resp1_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_data  (resp0_data),
    .resp0_err   (resp0_err),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_data  (resp1_data),
    .resp1_err   (resp1_err)
  );

  function automatic logic [31:0] ref_val(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] op);
    logic [31:0] fill;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: begin
        if (b >= 32) return 32'h0;
        return a / (32'h1 << b[4:0]);
      end
      3'd5: begin
        if (b >= 32) return a[31] ? 32'hFFFF_FFFF : 32'h0;
        fill = a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'h0;
        return (a / (32'h1 << b[4:0])) | fill;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op);
    return (op == 3'd6) || (op == 3'd7);
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    resp0_ready = 1; resp1_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Drives one command, waits (bounded) for the response.
  // wt = cycles waited for ready, lat = cycles from the
  // handshake cycle to the first resp_valid sample.
  task automatic send(input int p, input logic [31:0] a,
    input logic [31:0] b, input logic [2:0] op,
    output bit ok, output logic [31:0] d, output logic e,
    output int wt, output int lat);
    ok = 0; d = '0; e = 0; wt = -1; lat = 0;
    @(negedge clk);
    if (p == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((p == 0) ? req0_ready : req1_ready) begin
        wt = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (p == 0) req0_valid = 0;
    else        req1_valid = 0;
    if (wt < 0) return;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((p == 0) ? resp0_valid : resp1_valid) begin
        d = (p == 0) ? resp0_data : resp1_data;
        e = (p == 0) ? resp0_err : resp1_err;
        ok = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    req0_valid = 1; req1_valid = 1;
    #3;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid,
         resp0_err, resp1_err} !== 6'b0 ||
        resp0_data !== 32'h0 || resp1_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b%b vld=%b%b d0=%h d1=%h",
               req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp0_data, resp1_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0) begin
      failures++;
      $display("FAIL reset_ready_held rdy=%b%b exp=00",
               req0_ready, req1_ready);
    end
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_port0_add();
    bit ok; logic [31:0] d; logic e; int wt, lat;
    send(0, 32'd7, 32'd5, 3'd0, ok, d, e, wt, lat);
    checks++;
    if (!ok || wt != 0 || lat != 2) begin
      failures++;
      $display("FAIL p0_timing ok=%0d wait=%0d lat=%0d exp 1/0/2",
               ok, wt, lat);
    end
    checks++;
    if (d !== 32'd12 || e !== 1'b0) begin
      failures++;
      $display("FAIL p0_add got=%h err=%b exp=0000000c err=0", d, e);
    end
    checks++;
    if (resp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL p0_resp1_quiet got=%b exp=0", resp1_valid);
    end
  endtask

  task automatic test_port1_shifts();
    logic [31:0] bs[3];
    logic [2:0]  ops[3];
    logic [31:0] ex[3];
    bit ok; logic [31:0] d; logic e; int wt, lat;
    bs  = '{32'd4, 32'd4, 32'd40};
    ops = '{3'd5, 3'd4, 3'd5};
    ex  = '{32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      send(1, 32'h8000_0000, bs[i], ops[i], ok, d, e, wt, lat);
      checks++;
      if (!ok || d !== ex[i] || e !== 1'b0) begin
        failures++;
        $display("FAIL p1_shift%0d ok=%0d got=%h exp=%h",
                 i, ok, d, ex[i]);
      end
    end
  endtask

  task automatic test_alternate();
    int g[$];
    int n0 = 0, n1 = 0, r0 = 0, r1 = 0;
    bit drop0 = 0, drop1 = 0;
    do_reset();
    @(negedge clk);
    req0_a = 32'd3;    req0_b = 32'd5;    req0_op = 3'd1;
    req1_a = 32'h0F0;  req1_b = 32'h03C;  req1_op = 3'd2;
    req0_valid = 1; req1_valid = 1;
    for (int c = 0; c < 60; c++) begin
      if (r0 == 3 && r1 == 3) break;
      if (c != 0) @(negedge clk);
      if (drop0) req0_valid = 0;
      if (drop1) req1_valid = 0;
      #1;
      if (req0_ready) begin
        g.push_back(0);
        n0++;
        if (n0 == 3) drop0 = 1;
      end
      if (req1_ready) begin
        g.push_back(1);
        n1++;
        if (n1 == 3) drop1 = 1;
      end
      if (resp0_valid) begin
        r0++;
        checks++;
        if (resp0_data !== 32'hFFFF_FFFE) begin
          failures++;
          $display("FAIL alt_resp0 got=%h exp=fffffffe", resp0_data);
        end
      end
      if (resp1_valid) begin
        r1++;
        checks++;
        if (resp1_data !== 32'h30) begin
          failures++;
          $display("FAIL alt_resp1 got=%h exp=00000030", resp1_data);
        end
      end
    end
    checks++;
    if (g.size() != 6 || r0 != 3 || r1 != 3) begin
      failures++;
      $display("FAIL alt_count grants=%0d r0=%0d r1=%0d exp 6/3/3",
               g.size(), r0, r1);
    end
    for (int i = 0; i < g.size(); i++) begin
      checks++;
      if (g[i] != i % 2) begin
        failures++;
        $display("FAIL alt_order idx=%0d got=%0d exp=%0d",
                 i, g[i], i % 2);
      end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] d; logic e; int wt, lat;
    logic [31:0] a, b, ex;
    bit seen;
    a = $urandom; b = $urandom;
    ex = a + b;
    resp0_ready = 0;
    send(0, a, b, 3'd0, ok, d, e, wt, lat);
    req1_a = 32'h10; req1_b = 32'h20; req1_op = 3'd3;
    req1_valid = 1; req0_valid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (resp0_valid !== 1 || resp0_data !== ex ||
          req0_ready !== 0 || req1_ready !== 0) begin
        failures++;
        $display("FAIL bp_hold%0d v=%b d=%h exp=%h rdy=%b%b", i,
                 resp0_valid, resp0_data, ex, req0_ready, req1_ready);
      end
    end
    resp0_ready = 1;
    @(negedge clk);
    #1;
    checks++;
    if (resp0_valid !== 0 || req1_ready !== 1 || req0_ready !== 0) begin
      failures++;
      $display("FAIL bp_release v0=%b rdy=%b%b exp v0=0 rdy=01",
               resp0_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (resp1_valid) begin
        seen = 1;
        checks++;
        if (resp1_data !== 32'h30) begin
          failures++;
          $display("FAIL bp_held_req got=%h exp=00000030", resp1_data);
        end
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_held_timeout got=none exp=resp1");
    end
  endtask

  task automatic test_illegal();
    bit ok; logic [31:0] d; logic e; int wt, lat;
    logic [31:0] a, b;
    logic [2:0] op;
    send(1, $urandom, $urandom, 3'd6, ok, d, e, wt, lat);
    checks++;
    if (!ok || d !== 32'h0 || e !== 1'b1) begin
      failures++;
      $display("FAIL ill_110 ok=%0d got=%h err=%b exp=0 err=1",
               ok, d, e);
    end
    send(1, $urandom, $urandom, 3'd7, ok, d, e, wt, lat);
    checks++;
    if (!ok || d !== 32'h0 || e !== 1'b1) begin
      failures++;
      $display("FAIL ill_111 ok=%0d got=%h err=%b exp=0 err=1",
               ok, d, e);
    end
    a = $urandom; b = 32'($urandom_range(0, 35));
    op = 3'($urandom_range(0, 5));
    send(1, a, b, op, ok, d, e, wt, lat);
    checks++;
    if (!ok || d !== ref_val(a, b, op) || e !== 1'b0) begin
      failures++;
      $display("FAIL ill_recover got=%h err=%b exp=%h err=0",
               d, e, ref_val(a, b, op));
    end
  endtask

  task automatic test_reset_midop();
    bit seen;
    @(negedge clk);
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0;
    req0_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1) begin
      failures++;
      $display("FAIL rst_pre_ready got=%b exp=1", req0_ready);
    end
    @(posedge clk);
    #2;
    reset = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid,
         resp0_err, resp1_err} !== 6'b0 ||
        resp0_data !== 32'h0 || resp1_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_midop rdy=%b%b vld=%b%b d0=%h d1=%h",
               req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp0_data, resp1_data);
    end
    @(negedge clk);
    reset = 0;
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (resp0_valid !== 0 || resp1_valid !== 0) begin
        failures++;
        $display("FAIL rst_discard cyc=%0d vld=%b%b exp=00",
                 i, resp0_valid, resp1_valid);
      end
      @(negedge clk);
    end
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0;
    req1_a = 32'd4; req1_b = 32'd8; req1_op = 3'd3;
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      failures++;
      $display("FAIL rst_first_tie rdy=%b%b exp=10",
               req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (resp0_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || resp0_data !== 32'd3) begin
      failures++;
      $display("FAIL rst_after seen=%0d got=%h exp=00000003",
               seen, resp0_data);
    end
  endtask

  task automatic test_random();
    bit v[2];
    logic [31:0] ca[2], cb[2];
    logic [2:0] co[2];
    logic [32:0] q0[$], q1[$];
    int lg = 1;
    int ex;
    bit busy = 0;
    bit good;
    do_reset();
    v[0] = 0; v[1] = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && i < 380 && $urandom_range(0, 2) == 0) begin
          v[p] = 1;
          ca[p] = $urandom;
          cb[p] = ($urandom_range(0, 3) != 0) ?
                  32'($urandom_range(0, 40)) : $urandom;
          co[p] = 3'($urandom_range(0, 7));
        end
      end
      req0_valid = v[0]; req0_a = ca[0];
      req0_b = cb[0];    req0_op = co[0];
      req1_valid = v[1]; req1_a = ca[1];
      req1_b = cb[1];    req1_op = co[1];
      resp0_ready = (i >= 380) || ($urandom_range(0, 3) != 0);
      resp1_ready = (i >= 380) || ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (!busy && (v[0] || v[1])) begin
        if (v[0] && v[1]) ex = (lg == 0) ? 1 : 0;
        else              ex = v[1] ? 1 : 0;
        good = (ex == 0) ? (req0_ready && !req1_ready)
                         : (req1_ready && !req0_ready);
        if (!good) begin
          failures++;
          $display("FAIL rand_grant cyc=%0d rdy=%b%b exp_port=%0d",
                   i, req0_ready, req1_ready, ex);
        end
      end else if (req0_ready || req1_ready) begin
        failures++;
        $display("FAIL rand_busy_ready cyc=%0d rdy=%b%b exp=00",
                 i, req0_ready, req1_ready);
      end
      if (req0_ready) begin
        q0.push_back({ref_err(co[0]), ref_val(ca[0], cb[0], co[0])});
        lg = 0; v[0] = 0; busy = 1;
      end else if (req1_ready) begin
        q1.push_back({ref_err(co[1]), ref_val(ca[1], cb[1], co[1])});
        lg = 1; v[1] = 0; busy = 1;
      end
      if (resp0_valid || resp1_valid) begin
        checks++;
        if (resp0_valid && resp1_valid) begin
          failures++;
          $display("FAIL rand_both_valid cyc=%0d", i);
        end else if (resp0_valid) begin
          if (q0.size() == 0 || {resp0_err, resp0_data} !== q0[0]) begin
            failures++;
            $display("FAIL rand_resp0 cyc=%0d got=%h exp=%h", i,
                     {resp0_err, resp0_data},
                     (q0.size() != 0) ? q0[0] : 33'h0);
          end
          if (resp0_ready) begin
            if (q0.size() != 0) void'(q0.pop_front());
            busy = 0;
          end
        end else begin
          if (q1.size() == 0 || {resp1_err, resp1_data} !== q1[0]) begin
            failures++;
            $display("FAIL rand_resp1 cyc=%0d got=%h exp=%h", i,
                     {resp1_err, resp1_data},
                     (q1.size() != 0) ? q1[0] : 33'h0);
          end
          if (resp1_ready) begin
            if (q1.size() != 0) void'(q1.pop_front());
            busy = 0;
          end
        end
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || busy) begin
      failures++;
      $display("FAIL rand_drain q0=%0d q1=%0d busy=%0d exp 0/0/0",
               q0.size(), q1.size(), busy);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_port0_add();
    test_port1_shifts();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
